// File: rtl/tank_unit_if.sv
// Signal bundle between a player tank and the rest of the playfield logic.
// The playfield drives keys and collision status (master); the tank answers (slave).
interface tank_unit_if #(
    parameter int COORD_W = 10
);
    logic [7:0]         keycode;
    logic               tank_blocked;
    logic               tank_hit;
    logic               missile_busy;

    logic [COORD_W-1:0] tank_x;
    logic [COORD_W-1:0] tank_y;
    logic [1:0]         tank_dir;
    logic               missile_fire;
    logic [COORD_W-1:0] missile_x;
    logic [COORD_W-1:0] missile_y;
    logic               tank_visible;
    logic               tank_explosion;
    logic               game_over;
    logic [2:0]         lives;

    modport master (
        output keycode, tank_blocked, tank_hit, missile_busy,
        input  tank_x, tank_y, tank_dir, missile_fire, missile_x, missile_y,
        input  tank_visible, tank_explosion, game_over, lives
    );

    modport slave (
        input  keycode, tank_blocked, tank_hit, missile_busy,
        output tank_x, tank_y, tank_dir, missile_fire, missile_x, missile_y,
        output tank_visible, tank_explosion, game_over, lives
    );
endinterface

// File: rtl/tank_unit.sv
// Player tank: keyboard-driven movement, edge-triggered firing with cooldown, and a
// hit/explode/respawn/game-over life cycle. Optional macro TANK_SPAWN_SHIELD_EN adds a 90-frame spawn shield.
module tank_unit #(
    parameter int         COORD_W        = 10,
    parameter int         X_MAX          = 256,
    parameter int         Y_MAX          = 256,
    parameter int         TANK_SIZE      = 16,
    parameter int         STEP           = 1,
    parameter int         SPAWN_X        = 0,
    parameter int         SPAWN_Y        = 239,
    parameter int         FIRE_COOLDOWN  = 30,
    parameter int         EXPLODE_FRAMES = 16,
    parameter int         RESPAWN_FRAMES = 60,
    parameter int         LIVES          = 3,
    parameter logic [7:0] KEY_UP         = 8'h1d,
    parameter logic [7:0] KEY_LEFT       = 8'h1c,
    parameter logic [7:0] KEY_DOWN       = 8'h1b,
    parameter logic [7:0] KEY_RIGHT      = 8'h23,
    parameter logic [7:0] KEY_FIRE       = 8'h29
) (
    input logic        frame_clk,
    input logic        Reset,
    tank_unit_if.slave bus
);

    localparam int TMR_MAX = (EXPLODE_FRAMES > RESPAWN_FRAMES) ? EXPLODE_FRAMES : RESPAWN_FRAMES;
    localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);
    localparam int CD_W    = (FIRE_COOLDOWN < 2) ? 1 : $clog2(FIRE_COOLDOWN + 1);
    localparam int BW      = COORD_W + 1;

    localparam logic [BW-1:0]      STEP_B    = BW'(STEP);
    localparam logic [BW-1:0]      SIZE_B    = BW'(TANK_SIZE);
    localparam logic [BW-1:0]      XMAX_B    = BW'(X_MAX);
    localparam logic [BW-1:0]      YMAX_B    = BW'(Y_MAX);
    localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] SIZE_C    = COORD_W'(TANK_SIZE);
    localparam logic [COORD_W-1:0] HALF_C    = COORD_W'(TANK_SIZE / 2);
    localparam logic [COORD_W-1:0] SPAWN_X_C = COORD_W'(SPAWN_X);
    localparam logic [COORD_W-1:0] SPAWN_Y_C = COORD_W'(SPAWN_Y);
    localparam logic [TMR_W-1:0]   EXPLODE_T = TMR_W'(EXPLODE_FRAMES);
    localparam logic [TMR_W-1:0]   RESPAWN_T = TMR_W'(RESPAWN_FRAMES);
    localparam logic [TMR_W-1:0]   TMR_ONE   = TMR_W'(1);
    localparam logic [CD_W-1:0]    CD_LOAD   = CD_W'(FIRE_COOLDOWN);
    localparam logic [CD_W-1:0]    CD_ONE    = CD_W'(1);
    localparam logic [2:0]         LIVES_C   = 3'(LIVES);

    typedef enum logic [1:0] {ALIVE, EXPLODING, RESPAWN, DEAD} state_t;
    typedef enum logic [1:0] {DIR_UP = 2'b00, DIR_LEFT = 2'b01, DIR_DOWN = 2'b10, DIR_RIGHT = 2'b11} dir_t;

    state_t             state, state_next;
    dir_t               dir, key_dir;
    logic [COORD_W-1:0] x, y, x_moved, y_moved;
    logic [COORD_W-1:0] launch_x, launch_y, missile_x, missile_y;
    logic [TMR_W-1:0]   timer;
    logic [CD_W-1:0]    cooldown;
    logic [7:0]         prev_key;
    logic [2:0]         lives;
    logic               key_is_dir, in_bounds, can_move;
    logic               fire_req, fire_ok, hit_ok, timer_done;
    logic               missile_fire, visible, explosion, game_over;
    logic               visible_d, explosion_d, game_over_d;
    logic               shield_clear;

`ifdef TANK_SPAWN_SHIELD_EN
    localparam logic [6:0] SHIELD_T = 7'd90;
    logic [6:0] shield;

    assign shield_clear = (shield == 7'd0);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset)
            shield <= SHIELD_T;
        else if (state == RESPAWN && timer_done)
            shield <= SHIELD_T;
        else if (state == ALIVE && !shield_clear)
            shield <= shield - 7'd1;
    end
`else
    assign shield_clear = 1'b1;
`endif

    assign hit_ok     = (state == ALIVE) && bus.tank_hit && shield_clear;
    assign fire_req   = (bus.keycode == KEY_FIRE) && (prev_key != KEY_FIRE);
    assign fire_ok    = (state == ALIVE) && !hit_ok && fire_req &&
                        (cooldown == '0) && !bus.missile_busy;
    assign timer_done = (timer <= TMR_ONE);
    assign can_move   = key_is_dir && in_bounds && !bus.tank_blocked;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        key_is_dir = 1'b1;
        key_dir    = DIR_UP;
        if (bus.keycode == KEY_UP)         key_dir = DIR_UP;
        else if (bus.keycode == KEY_LEFT)  key_dir = DIR_LEFT;
        else if (bus.keycode == KEY_DOWN)  key_dir = DIR_DOWN;
        else if (bus.keycode == KEY_RIGHT) key_dir = DIR_RIGHT;
        else                               key_is_dir = 1'b0;
    end

    // Bound tests run one bit wider than the coordinates so edge sums cannot wrap.
    always_comb begin
        in_bounds = 1'b0;
        x_moved   = x;
        y_moved   = y;
        unique case (key_dir)
            DIR_UP: begin
                in_bounds = ({1'b0, y} >= STEP_B);
                y_moved   = y - STEP_C;
            end
            DIR_LEFT: begin
                in_bounds = ({1'b0, x} >= STEP_B);
                x_moved   = x - STEP_C;
            end
            DIR_DOWN: begin
                in_bounds = (({1'b0, y} + SIZE_B + STEP_B) <= YMAX_B);
                y_moved   = y + STEP_C;
            end
            DIR_RIGHT: begin
                in_bounds = (({1'b0, x} + SIZE_B + STEP_B) <= XMAX_B);
                x_moved   = x + STEP_C;
            end
        endcase
    end

    // Launch point sits on the centre of the facing edge.
    always_comb begin
        launch_x = x;
        launch_y = y;
        unique case (dir)
            DIR_UP:    begin launch_x = x + HALF_C; launch_y = y;          end
            DIR_LEFT:  begin launch_x = x;          launch_y = y + HALF_C; end
            DIR_DOWN:  begin launch_x = x + HALF_C; launch_y = y + SIZE_C; end
            DIR_RIGHT: begin launch_x = x + SIZE_C; launch_y = y + HALF_C; end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) state <= ALIVE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ALIVE:     if (hit_ok) state_next = EXPLODING;
            EXPLODING: if (timer_done) state_next = (lives == 3'd0) ? DEAD : RESPAWN;
            RESPAWN:   if (timer_done) state_next = ALIVE;
            DEAD:      state_next = DEAD;
        endcase
    end

    // Status flags are decoded from the next state and registered alongside it.
    always_comb begin
        visible_d   = (state_next == ALIVE) || (state_next == EXPLODING);
        explosion_d = (state_next == EXPLODING);
        game_over_d = (state_next == DEAD);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            x            <= SPAWN_X_C;
            y            <= SPAWN_Y_C;
            dir          <= DIR_UP;
            lives        <= LIVES_C;
            cooldown     <= '0;
            timer        <= '0;
            prev_key     <= 8'h00;
            missile_fire <= 1'b0;
            missile_x    <= '0;
            missile_y    <= '0;
            visible      <= 1'b1;
            explosion    <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            prev_key     <= bus.keycode;
            missile_fire <= fire_ok;
            visible      <= visible_d;
            explosion    <= explosion_d;
            game_over    <= game_over_d;
            if (cooldown != '0)
                cooldown <= cooldown - CD_ONE;

            unique case (state)
                ALIVE: begin
                    if (hit_ok) begin
                        lives <= lives - 3'd1;
                        timer <= EXPLODE_T;
                    end else begin
                        if (key_is_dir)
                            dir <= key_dir;
                        if (can_move) begin
                            x <= x_moved;
                            y <= y_moved;
                        end
                        if (fire_ok) begin
                            missile_x <= launch_x;
                            missile_y <= launch_y;
                            cooldown  <= CD_LOAD;
                        end
                    end
                end
                EXPLODING: begin
                    if (timer_done) timer <= RESPAWN_T;
                    else            timer <= timer - TMR_ONE;
                end
                RESPAWN: begin
                    if (timer_done) begin
                        x        <= SPAWN_X_C;
                        y        <= SPAWN_Y_C;
                        dir      <= DIR_UP;
                        cooldown <= '0;
                        timer    <= '0;
                    end else begin
                        timer <= timer - TMR_ONE;
                    end
                end
                DEAD: ;
            endcase
        end
    end

    assign bus.tank_x         = x;
    assign bus.tank_y         = y;
    assign bus.tank_dir       = dir;
    assign bus.missile_fire   = missile_fire;
    assign bus.missile_x      = missile_x;
    assign bus.missile_y      = missile_y;
    assign bus.tank_visible   = visible;
    assign bus.tank_explosion = explosion;
    assign bus.game_over      = game_over;
    assign bus.lives          = lives;

endmodule

// File: tb/tb_tank_unit.sv
// Self-checking bench for tank_unit: movement vector table, launch scoreboard,
// and hand-written hit/respawn/reset sequences.
module tb_tank_unit;
    localparam logic [7:0] K_UP    = 8'h1d;
    localparam logic [7:0] K_LEFT  = 8'h1c;
    localparam logic [7:0] K_DOWN  = 8'h1b;
    localparam logic [7:0] K_RIGHT = 8'h23;
    localparam logic [7:0] K_FIRE  = 8'h29;
`ifdef TANK_SPAWN_SHIELD_EN
    localparam int SHIELD_WAIT = 90;
`else
    localparam int SHIELD_WAIT = 0;
`endif

    logic frame_clk = 1'b0;
    logic Reset;
    always #5 frame_clk = ~frame_clk;

    tank_unit_if #(.COORD_W(10)) bus();
    tank_unit #(.COORD_W(10)) dut (.frame_clk(frame_clk), .Reset(Reset), .bus(bus));

    typedef struct { int x; int y; } shot_t;
    typedef struct {
        string      name;
        logic [7:0] key;
        logic       blocked;
        int         frames;
        int         ex;
        int         ey;
        int         edir;
    } vec_t;

    shot_t sb[$];
    vec_t  vecs[12];
    int    checks = 0;
    int    errors = 0;
    int    pulses = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic drive(input logic [7:0] key, input logic blk, input logic hit, input logic busy);
        bus.keycode      = key;
        bus.tank_blocked = blk;
        bus.tank_hit     = hit;
        bus.missile_busy = busy;
    endtask

    // Advance n frames; every launch pulse is matched against the scoreboard.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge frame_clk);
            #1;
            if (bus.missile_fire === 1'b1) begin
                pulses++;
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    shot_t s;
                    s = sb.pop_front();
                    check("missile_x", 32'(bus.missile_x), 32'(s.x));
                    check("missile_y", 32'(bus.missile_y), 32'(s.y));
                end
            end
        end
    endtask

    task automatic expect_shot(input int sx, input int sy);
        shot_t s;
        s.x = sx;
        s.y = sy;
        sb.push_back(s);
    endtask

    task automatic check_pos(input string name, input int ex, input int ey, input int edir);
        check({name, "_pos"}, {12'd0, 32'(bus.tank_x) << 10 | 32'(bus.tank_y), 2'(bus.tank_dir)}[31:0],
              {12'd0, 32'(ex) << 10 | 32'(ey), 2'(edir)}[31:0]);
    endtask

    task automatic check_status(input string name, input int elives, input int vis, input int expl, input int go);
        check({name, "_lives"}, 32'(bus.lives), 32'(elives));
        check({name, "_flags"}, {29'd0, bus.tank_visible, bus.tank_explosion, bus.game_over},
              {29'd0, 1'(vis), 1'(expl), 1'(go)});
    endtask

    task automatic check_reset_outputs(input string name);
        check_pos(name, 0, 239, 0);
        check_status(name, 3, 1, 0, 0);
        check({name, "_missile"}, {11'd0, bus.missile_fire, 10'(bus.missile_x), 10'(bus.missile_y)}, 32'd0);
    endtask

    initial begin
        logic [7:0] dkeys[4];
        int         dex[4];
        int         dey[4];

        vecs[0]  = '{"idle",         8'h00,   1'b0,   3,   0, 239, 0};
        vecs[1]  = '{"left_bound",   K_LEFT,  1'b0,   3,   0, 239, 1};
        vecs[2]  = '{"right_300",    K_RIGHT, 1'b0, 300, 240, 239, 3};
        vecs[3]  = '{"up_blocked",   K_UP,    1'b1,   5, 240, 239, 0};
        vecs[4]  = '{"down_bound",   K_DOWN,  1'b0,   4, 240, 240, 2};
        vecs[5]  = '{"left_blocked", K_LEFT,  1'b1,   3, 240, 240, 1};
        vecs[6]  = '{"left_140",     K_LEFT,  1'b0, 140, 100, 240, 1};
        vecs[7]  = '{"up_250",       K_UP,    1'b0, 250, 100,   0, 0};
        vecs[8]  = '{"down_50",      K_DOWN,  1'b0,  50, 100,  50, 2};
        vecs[9]  = '{"face_right",   K_RIGHT, 1'b1,   2, 100,  50, 3};
        vecs[10] = '{"other_key",    8'h44,   1'b0,   3, 100,  50, 3};
        vecs[11] = '{"release",      8'h00,   1'b0,   2, 100,  50, 3};
        dkeys = '{K_UP, K_LEFT, K_DOWN, K_RIGHT};
        dex   = '{108, 100, 108, 116};
        dey   = '{ 50,  58,  66,  58};

        drive(8'h00, 1'b0, 1'b0, 1'b0);
        Reset = 1'b1;
        step(2);
        check_reset_outputs("reset");
        Reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].key, vecs[i].blocked, 1'b0, 1'b0);
            step(vecs[i].frames);
            check_pos(vecs[i].name, vecs[i].ex, vecs[i].ey, vecs[i].edir);
        end
        check_status("after_moves", 3, 1, 0, 0);

        // Held fire: one launch only.
        drive(K_FIRE, 1'b0, 1'b0, 1'b0);
        expect_shot(116, 58);
        step(100);
        check("hold_fire_pulses", 32'(pulses), 32'd1);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        step(1);

        // Cooldown: re-press at +9 rejected, at +40 accepted.
        drive(K_FIRE, 1'b0, 1'b0, 1'b0); expect_shot(116, 58); step(1);
        drive(8'h00, 1'b0, 1'b0, 1'b0);  step(8);
        drive(K_FIRE, 1'b0, 1'b0, 1'b0); step(1);
        drive(8'h00, 1'b0, 1'b0, 1'b0);  step(30);
        drive(K_FIRE, 1'b0, 1'b0, 1'b0); expect_shot(116, 58); step(1);
        drive(8'h00, 1'b0, 1'b0, 1'b0);  step(31);
        check("cooldown_queue", 32'(sb.size()), 32'd0);
        check("cooldown_pulses", 32'(pulses), 32'd3);

        // Own missile in flight: request dropped, not queued.
        drive(K_FIRE, 1'b0, 1'b0, 1'b1); step(1);
        drive(8'h00, 1'b0, 1'b0, 1'b0);  step(3);
        check("busy_dropped", 32'(pulses), 32'd3);
        drive(K_FIRE, 1'b0, 1'b0, 1'b0); expect_shot(116, 58); step(1);
        drive(8'h00, 1'b0, 1'b0, 1'b0);  step(31);

        for (int d = 0; d < 4; d++) begin
            drive(dkeys[d], 1'b1, 1'b0, 1'b0); step(1);
            drive(8'h00, 1'b0, 1'b0, 1'b0);    step(1);
            drive(K_FIRE, 1'b0, 1'b0, 1'b0);   expect_shot(dex[d], dey[d]); step(1);
            drive(8'h00, 1'b0, 1'b0, 1'b0);    step(31);
        end
        check("direction_queue", 32'(sb.size()), 32'd0);
        check_pos("after_fire", 100, 50, 3);

        // Hit with fire in the same frame: hit wins, no launch.
        drive(K_FIRE, 1'b0, 1'b1, 1'b0); step(1);
        check_status("hit1", 2, 1, 1, 0);
        check_pos("hit1", 100, 50, 3);
        step(14);
        check_status("hit_ignored_exploding", 2, 1, 1, 0);
        drive(8'h00, 1'b0, 1'b0, 1'b0); step(1);
        check_status("explode_last", 2, 1, 1, 0);
        step(1);
        check_status("respawn_first", 2, 0, 0, 0);
        drive(K_RIGHT, 1'b0, 1'b1, 1'b0); step(59);
        check_status("respawn_last", 2, 0, 0, 0);
        check_pos("respawn_frozen", 100, 50, 3);
        drive(8'h00, 1'b0, 1'b0, 1'b0); step(1);
        check_status("respawned", 2, 1, 0, 0);
        check_pos("respawned", 0, 239, 0);
        check("respawn_no_pulse", 32'(pulses), 32'd8);

        step(SHIELD_WAIT);
        drive(8'h00, 1'b0, 1'b1, 1'b0); step(1);
        check_status("hit2", 1, 1, 1, 0);
        drive(8'h00, 1'b0, 1'b0, 1'b0); step(76);
        check_status("respawned2", 1, 1, 0, 0);

        step(SHIELD_WAIT);
        drive(8'h00, 1'b0, 1'b1, 1'b0); step(1);
        check_status("hit3", 0, 1, 1, 0);
        drive(8'h00, 1'b0, 1'b0, 1'b0); step(15);
        check_status("hit3_exploding", 0, 1, 1, 0);
        step(1);
        check_status("dead", 0, 0, 0, 1);
        drive(K_RIGHT, 1'b0, 1'b1, 1'b0); step(100);
        check_status("dead_stays", 0, 0, 0, 1);
        check_pos("dead_frozen", 0, 239, 0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);

        Reset = 1'b1; #1;
        check_status("reset_from_dead", 3, 1, 0, 0);
        Reset = 1'b0;

        // Asynchronous reset in the middle of an explosion.
        step(SHIELD_WAIT);
        drive(8'h00, 1'b0, 1'b1, 1'b0); step(1);
        drive(8'h00, 1'b0, 1'b0, 1'b0); step(5);
        check_status("mid_explode", 2, 1, 1, 0);
        Reset = 1'b1; #2;
        check_reset_outputs("reset_mid_explode");
        Reset = 1'b0;
        drive(8'h00, 1'b0, 1'b1, 1'b0); step(SHIELD_WAIT);
        check_status("post_reset_shield", 3, 1, 0, 0);
        step(1);
        check_status("post_reset_hit", 2, 1, 1, 0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset clears a running cooldown.
        Reset = 1'b1; #1; Reset = 1'b0;
        step(1);
        drive(K_FIRE, 1'b0, 1'b0, 1'b0); expect_shot(8, 239); step(1);
        drive(8'h00, 1'b0, 1'b0, 1'b0);  step(3);
        Reset = 1'b1; #1;
        check({"reset_mid_cooldown", "_missile"}, {11'd0, bus.missile_fire, 10'(bus.missile_x), 10'(bus.missile_y)}, 32'd0);
        Reset = 1'b0;
        drive(K_FIRE, 1'b0, 1'b0, 1'b0); expect_shot(8, 239); step(1);
        drive(8'h00, 1'b0, 1'b0, 1'b0);  step(2);
        check("final_queue", 32'(sb.size()), 32'd0);
        check("final_pulses", 32'(pulses), 32'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
